// File: rtl/serial_frame_ctrl.sv
// Wishbone-programmed serial frame scheduler: FIFO of frames shifted out LSB-first
// at a programmable bit period, with a programmable idle gap between frames.
module serial_frame_ctrl #(
  parameter int unsigned FRAME_W    = 10,
  parameter int unsigned DIV_W      = 16,
  parameter int unsigned FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic        cyc_i,
  input  logic        stb_i,
  input  logic        we_i,
  input  logic [1:0]  adr_i,
  input  logic [31:0] dat_i,
  output logic [31:0] dat_o,
  output logic        ack_o,
  output logic        data_o,
  output logic        ena_o,
  output logic        busy_o
);

  localparam int unsigned PTR_W = $clog2(FIFO_DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;
  localparam logic [7:0]  IDX_LAST = 8'(FRAME_W - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_SHIFT, ST_GAP} state_e;

  state_e               state_q, state_d;
  logic                 ack_q, ack_d;
  logic [31:0]          dat_o_q, dat_o_d;
  logic [DIV_W-1:0]     div_q, div_d;
  logic                 en_q, en_d;
  logic [7:0]           gap_q, gap_d;
  logic                 ovf_q, ovf_d;
  logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [LVL_W-1:0]     level_q, level_d;
  logic [FRAME_W-1:0]   sr_q, sr_d;
  logic [DIV_W-1:0]     div_lat_q, div_lat_d, cnt_q, cnt_d;
  logic [7:0]           gap_lat_q, gap_lat_d, idx_q, idx_d;
  logic [FRAME_W-1:0]   fifo_mem [FIFO_DEPTH];

  logic        bus_req, wr, rd, full, empty, push_req, push, pop;
  logic        ena, data;
  logic [31:0] rd_data;
  logic        unused_dat;

  assign unused_dat = ^dat_i;
  assign bus_req    = cyc_i & stb_i & ~ack_q;
  assign wr         = bus_req & we_i;
  assign rd         = bus_req & ~we_i;
  assign full       = (level_q == LVL_W'(FIFO_DEPTH));
  assign empty      = (level_q == '0);
  assign push_req   = wr && (adr_i == 2'd0);
  // A pop on the same edge frees the slot, so a push into a full FIFO still lands.
  assign push       = push_req && (!full || pop);

  always_comb begin
    state_d   = state_q;
    sr_d      = sr_q;
    div_lat_d = div_lat_q;
    gap_lat_d = gap_lat_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    pop       = 1'b0;
    ena       = 1'b0;
    data      = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en_q && !empty) begin
          pop       = 1'b1;
          sr_d      = fifo_mem[rd_ptr_q];
          div_lat_d = div_q;
          gap_lat_d = gap_q;
          cnt_d     = '0;
          idx_d     = '0;
          state_d   = ST_SHIFT;
        end
      end
      ST_SHIFT: begin
        ena  = 1'b1;
        data = sr_q[0];
        if (cnt_q == div_lat_q) begin
          cnt_d = '0;
          sr_d  = sr_q >> 1;
          if (idx_q == IDX_LAST) begin
            idx_d   = '0;
            state_d = (gap_lat_q != '0) ? ST_GAP : ST_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      ST_GAP: begin
        if (cnt_q == div_lat_q) begin
          cnt_d = '0;
          if (idx_q == gap_lat_q - 8'd1) begin
            idx_d   = '0;
            state_d = ST_IDLE;
          end else begin
            idx_d = idx_q + 8'd1;
          end
        end else begin
          cnt_d = cnt_q + DIV_W'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    rd_data = '0;
    case (adr_i)
      2'd1: rd_data[DIV_W-1:0] = div_q;
      2'd2: begin
        rd_data[0]          = (state_q != ST_IDLE);
        rd_data[1]          = empty;
        rd_data[2]          = full;
        rd_data[3]          = ovf_q;
        rd_data[4 +: LVL_W] = level_q;
      end
      2'd3: begin
        rd_data[0]    = en_q;
        rd_data[15:8] = gap_q;
      end
      default: rd_data = '0;
    endcase
  end

  always_comb begin
    ack_d    = cyc_i & stb_i & ~ack_q;
    dat_o_d  = rd ? rd_data : '0;
    div_d    = div_q;
    en_d     = en_q;
    gap_d    = gap_q;
    ovf_d    = ovf_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    level_d  = level_q;
    if (wr) begin
      case (adr_i)
        2'd1: div_d = dat_i[DIV_W-1:0];
        2'd2: if (dat_i[3]) ovf_d = 1'b0;
        2'd3: begin
          en_d  = dat_i[0];
          gap_d = dat_i[15:8];
        end
        default: ;
      endcase
    end
    if (push_req && full && !pop) ovf_d = 1'b1;
    if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
    if (push && !pop) level_d = level_q + LVL_W'(1);
    else if (pop && !push) level_d = level_q - LVL_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (push) fifo_mem[wr_ptr_q] <= dat_i[FRAME_W-1:0];
  end

  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state_q   <= ST_IDLE;
      ack_q     <= 1'b0;
      dat_o_q   <= '0;
      div_q     <= DIV_W'(3);
      en_q      <= 1'b0;
      gap_q     <= 8'd2;
      ovf_q     <= 1'b0;
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      level_q   <= '0;
      sr_q      <= '0;
      div_lat_q <= '0;
      gap_lat_q <= '0;
      cnt_q     <= '0;
      idx_q     <= '0;
    end else begin
      state_q   <= state_d;
      ack_q     <= ack_d;
      dat_o_q   <= dat_o_d;
      div_q     <= div_d;
      en_q      <= en_d;
      gap_q     <= gap_d;
      ovf_q     <= ovf_d;
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      level_q   <= level_d;
      sr_q      <= sr_d;
      div_lat_q <= div_lat_d;
      gap_lat_q <= gap_lat_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
    end
  end

  assign ack_o  = ack_q;
  assign dat_o  = dat_o_q;
  assign data_o = data;
  assign ena_o  = ena;
  assign busy_o = (state_q != ST_IDLE);

endmodule

// File: doc/serial_frame_ctrl.md
# serial_frame_ctrl

Wishbone-configured scheduler that sequences the 10-bit serial frame datapath. Software writes frames into a small FIFO over a Wishbone slave port. The block then shifts each frame out LSB-first on `data_o` at a programmable bit period, asserting `ena_o` for the duration of each frame and inserting a programmable idle gap between frames. It sits between the bus fabric and the serial line/receiver, replacing direct bit-banging of `inputdata_i`.

## Interface
Parameters:
- `FRAME_W`, 10: bits per frame
- `DIV_W`, 16: width of bit-period divider
- `FIFO_DEPTH`, 4: frame FIFO entries, power of 2, ≥2

Ports (name, direction, width, meaning):
- `clk_i`, in, 1: single clock
- `rstn_i`, in, 1: reset, asynchronous, active-low
- `cyc_i`, in, 1: Wishbone cycle
- `stb_i`, in, 1: Wishbone strobe
- `we_i`, in, 1: write enable
- `adr_i`, in, 2: register select (word index)
- `dat_i`, in, 32: write data
- `dat_o`, out, 32: read data; valid while `ack_o`=1
- `ack_o`, out, 1: single-cycle acknowledge
- `data_o`, out, 1: serial bit
- `ena_o`, out, 1: high while frame bits are driven on `data_o`
- `busy_o`, out, 1: FSM not IDLE

## Operation
Registers:
- 0 TXDATA (write-only): push `dat_i[FRAME_W-1:0]`; when FIFO full, write is acked and dropped, sticky OVF set; reads return 0
- 1 DIV (rw): `[DIV_W-1:0]` = clocks per bit minus 1; reset 3
- 2 STATUS: `[0]` busy, `[1]` empty, `[2]` full, `[3]` OVF, `[6:4]` level; writing 1 to bit 3 clears OVF; other bits read-only
- 3 CTRL (rw): `[0]` EN, reset 0; `[15:8]` GAP, idle bit-times between frames, reset 2
- Unused read bits are 0

Bus:
- `ack_o` is registered: `ack_o <= cyc_i & stb_i & ~ack_o`
- A write commits at the edge that raises `ack_o`
- No wait states; no error/retry

FSM:
- IDLE: `data_o`=0, `ena_o`=0. If EN=1 and FIFO non-empty: pop into shift register, latch DIV, clear counters, go to SHIFT
- SHIFT: `ena_o`=1, `data_o`=sr[0]. Each bit is held DIV+1 clocks, then sr shifts right. After bit FRAME_W-1 completes: go to GAP if GAP≠0, else IDLE
- GAP: `data_o`=0, `ena_o`=0 for GAP×(DIV+1) clocks, then IDLE
- A frame in progress always completes: clearing EN mid-frame stops only subsequent frames
- DIV writes mid-frame take effect at the next frame start
- DIV=0 gives 1 clock per bit

Boundary conditions:
- Push and pop on the same edge with FIFO full: both succeed, level unchanged, no OVF
- Push and pop on the same edge with FIFO empty: not possible, since pop requires non-empty
- OVF set and clear on the same edge: set wins
- Reset at any time: FIFO flushed, FSM to IDLE, all registers to reset values

## Timing
- Reset values: `ack_o`=0, `dat_o`=0, `data_o`=0, `ena_o`=0, `busy_o`=0
- Latency with EN=1, IDLE, FIFO empty: if TXDATA write commits at edge T, FIFO is non-empty after T, FSM enters SHIFT at edge T+1, and `ena_o`/first bit appear after T+1
- Frame length: exactly FRAME_W×(DIV+1) clocks of `ena_o`=1
- Frame-to-frame spacing with FIFO non-empty: GAP×(DIV+1) clocks of GAP, plus 1 IDLE clock
- `busy_o` is high in SHIFT and GAP
- STATUS level reflects the FIFO after the previous edge

## Test plan
- Reset: hold `rstn_i`=0, 2 clocks → all outputs 0; STATUS reads 0x02; DIV reads 3; CTRL reads 0x0200
- Single frame: EN=1, DIV=3, write TXDATA=10'b1001110100 → `ena_o` high 40 clocks; `data_o` carries 0,0,1,0,1,1,1,0,0,1, each bit 4 clocks; `ena_o` rises one clock after the write ack edge
- Overflow: EN=0, write 5 frames → STATUS level=4, full=1, OVF=1; enable EN → exactly 4 frames sent, fifth dropped; write STATUS bit3=1 clears OVF
- Gap/back-to-back: DIV=0, GAP=0, 2 frames queued → second `ena_o` run starts 1 clock (one IDLE cycle) after the first ends; with GAP=2, spacing is 3 clocks
- EN cleared mid-frame: current frame finishes all 10 bits; the next queued frame stays in the FIFO (level unchanged)
- Async reset mid-frame: assert `rstn_i` at bit 5 → `ena_o`/`data_o` drop to 0 immediately, without waiting for a clock; FIFO level reads 0 after release
